// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: ALU-control decode, 32-bit ALU and branch-target adder, with EX/MEM-ready registered outputs.
// Optional signed-overflow output is built only when ALU_OVERFLOW_EN is defined.
module ex_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_pc_plus4,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic [WIDTH-1:0] i_imm_ext,
    input  logic             i_alu_src,
    input  logic [2:0]       i_alu_op,
    output logic [3:0]       o_operation,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic [WIDTH-1:0] o_branch_target
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             o_overflow
`endif
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_ILL = 4'b1111;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [5:0]       w_funct;
    logic [4:0]       w_shamt;
    logic [3:0]       w_operation;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_branch;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_branch_target;

    assign w_a     = i_op1;
    assign w_b     = i_alu_src ? i_imm_ext : i_op2;
    assign w_funct = i_imm_ext[5:0];
    assign w_shamt = i_imm_ext[10:6];

    always_comb begin
        w_operation = OP_ILL;
        case (i_alu_op)
            3'b000: w_operation = OP_ADD;
            3'b001: w_operation = OP_SUB;
            3'b010: begin
                case (w_funct)
                    6'b100000: w_operation = OP_ADD;
                    6'b100010: w_operation = OP_SUB;
                    6'b100100: w_operation = OP_AND;
                    6'b100101: w_operation = OP_OR;
                    6'b100110: w_operation = OP_XOR;
                    6'b100111: w_operation = OP_NOR;
                    6'b101010: w_operation = OP_SLT;
                    6'b000000: w_operation = OP_SLL;
                    6'b000010: w_operation = OP_SRL;
                    default:   w_operation = OP_ILL;
                endcase
            end
            3'b011: w_operation = OP_AND;
            3'b100: w_operation = OP_OR;
            3'b101: w_operation = OP_SLT;
            3'b110: w_operation = OP_XOR;
            3'b111: w_operation = OP_NOR;
            default: w_operation = OP_ILL;
        endcase
    end

    assign o_operation = w_operation;

    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;
    // Signed compare rather than the sign of the difference, so SLT stays right across overflow.
    assign w_lt   = ($signed(w_a) < $signed(w_b));

    always_comb begin
        w_alu = '0;
        case (w_operation)
            OP_AND:  w_alu = w_a & w_b;
            OP_OR:   w_alu = w_a | w_b;
            OP_ADD:  w_alu = w_sum;
            OP_SUB:  w_alu = w_diff;
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_lt};
            OP_NOR:  w_alu = ~(w_a | w_b);
            OP_XOR:  w_alu = w_a ^ w_b;
            OP_SLL:  w_alu = w_b << w_shamt;
            OP_SRL:  w_alu = w_b >> w_shamt;
            default: w_alu = '0;
        endcase
    end

    assign w_branch = i_pc_plus4 + {i_imm_ext[WIDTH-3:0], 2'b00};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_result        <= '0;
            r_zero          <= 1'b0;
            r_branch_target <= '0;
        end else if (i_en) begin
            r_result        <= w_alu;
            r_zero          <= (w_alu == '0);
            r_branch_target <= w_branch;
        end
    end

    assign o_result        = r_result;
    assign o_zero          = r_zero;
    assign o_branch_target = r_branch_target;

`ifdef ALU_OVERFLOW_EN
    logic w_ovf;
    logic r_overflow;

    always_comb begin
        w_ovf = 1'b0;
        case (w_operation)
            OP_ADD:  w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            OP_SUB:  w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_en) begin
            r_overflow <= w_ovf;
        end
    end

    assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: expected EX/MEM values are queued at drive time and popped one edge later.
module tb_ex_alu_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] pc_plus4;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm_ext;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic [3:0]  operation;
    logic [31:0] result;
    logic        zero;
    logic [31:0] branch_target;
    logic        overflow;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [31:0] bt;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    ex_alu_unit #(.WIDTH(32)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_en            (en),
        .i_pc_plus4      (pc_plus4),
        .i_op1           (op1),
        .i_op2           (op2),
        .i_imm_ext       (imm_ext),
        .i_alu_src       (alu_src),
        .i_alu_op        (alu_op),
        .o_operation     (operation),
        .o_result        (result),
        .o_zero          (zero),
        .o_branch_target (branch_target)
`ifdef ALU_OVERFLOW_EN
        ,
        .o_overflow      (overflow)
`endif
    );

`ifndef ALU_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model_op(input logic [2:0] aop, input logic [5:0] funct);
        case (aop)
            3'd0: return 4'b0010;
            3'd1: return 4'b0110;
            3'd3: return 4'b0000;
            3'd4: return 4'b0001;
            3'd5: return 4'b0111;
            3'd6: return 4'b0011;
            3'd7: return 4'b1100;
            default: begin
                if (funct == 6'h20) return 4'b0010;
                if (funct == 6'h22) return 4'b0110;
                if (funct == 6'h24) return 4'b0000;
                if (funct == 6'h25) return 4'b0001;
                if (funct == 6'h26) return 4'b0011;
                if (funct == 6'h27) return 4'b1100;
                if (funct == 6'h2A) return 4'b0111;
                if (funct == 6'h00) return 4'b1000;
                if (funct == 6'h02) return 4'b1001;
                return 4'b1111;
            end
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b_reg,
                                   input logic [31:0] imm, input logic src, input logic [2:0] aop);
        exp_t e;
        logic [31:0] b;
        logic [32:0] wide;
        int sa;
        b  = src ? imm : b_reg;
        sa = int'(imm[10:6]);
        e.ovf = 1'b0;
        case (model_op(aop, imm[5:0]))
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                wide  = {a[31], a} + {b[31], b};
                e.res = wide[31:0];
                e.ovf = wide[32] ^ wide[31];
            end
            4'b0110: begin
                wide  = {a[31], a} - {b[31], b};
                e.res = wide[31:0];
                e.ovf = wide[32] ^ wide[31];
            end
            4'b0111: e.res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b1100: e.res = ~(a | b);
            4'b0011: e.res = a ^ b;
            4'b1000: e.res = b << sa;
            4'b1001: e.res = b >> sa;
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        e.bt   = pc + (imm << 2);
        return e;
    endfunction

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".result"}, result, e.res);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
        check({tag, ".target"}, branch_target, e.bt);
`ifdef ALU_OVERFLOW_EN
        check({tag, ".ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
`endif
    endtask

    // Drive one transaction with en=1, check the combinational decode, then check the registered result.
    task automatic apply(input string tag, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src, input logic [2:0] aop);
        exp_t e;
        pc_plus4 = pc;
        op1      = a;
        op2      = b;
        imm_ext  = imm;
        alu_src  = src;
        alu_op   = aop;
        en       = 1'b1;
        #1;
        check({tag, ".op"}, {28'd0, operation}, {28'd0, model_op(aop, imm[5:0])});
        sb.push_back(model(pc, a, b, imm, src, aop));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            compare_outputs(tag, e);
            last_exp = e;
            $display("vec %-10s aop=%0d op=%b a=%08h b=%08h imm=%08h -> res=%08h z=%0b bt=%08h",
                     tag, aop, operation, a, b, imm, result, zero, branch_target);
        end
    endtask

    logic [5:0] functs [10];

    initial begin
        exp_t zero_exp;
        logic [5:0] f;
        vectors     = 0;
        miscompares = 0;
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};
        zero_exp = '{res: 32'd0, zero: 1'b0, bt: 32'd0, ovf: 1'b0};

        // Reset held for two edges with enable and nonzero inputs.
        rst_n = 1'b0; en = 1'b1;
        pc_plus4 = 32'h400; op1 = 32'h11; op2 = 32'h22; imm_ext = 32'h20;
        alu_src = 1'b0; alu_op = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        compare_outputs("reset", zero_exp);
        rst_n = 1'b1;

        apply("radd",   32'h0000_0000, 32'd5,         32'd7,         32'h0000_0020, 1'b0, 3'b010);
        apply("beq",    32'h0000_0100, 32'h1234,      32'h1234,      32'hFFFF_FFFF, 1'b0, 3'b001);
        apply("slt_a",  32'h0000_0010, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b1, 3'b101);
        apply("slt_b",  32'h0000_0010, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3'b101);
        apply("slt_ov", 32'h0000_0010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_002A, 1'b0, 3'b010);
        apply("sll",    32'h0000_0020, 32'd0,         32'd3,         32'h0000_0100, 1'b0, 3'b010);
        apply("srl",    32'h0000_0020, 32'd0,         32'h8000_0000, 32'h0000_07C2, 1'b0, 3'b010);
        apply("illegal",32'h0000_0030, 32'd9,         32'd9,         32'h0000_003F, 1'b0, 3'b010);
        apply("and",    32'h0000_0040, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0,         1'b0, 3'b011);
        apply("or",     32'h0000_0040, 32'hF0F0_F0F0, 32'h0F00_0000, 32'd0,         1'b0, 3'b100);
        apply("xor",    32'h0000_0040, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0,         1'b0, 3'b110);
        apply("nor",    32'h0000_0040, 32'h0000_FFFF, 32'h00FF_0000, 32'd0,         1'b0, 3'b111);
        apply("addiov", 32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'd0,         32'd1,         1'b1, 3'b000);
        apply("subov",  32'h0000_0004, 32'h8000_0000, 32'd1,         32'h0000_0022, 1'b0, 3'b010);

        // Stall: inputs change, outputs must hold.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op1 = $urandom; op2 = $urandom; imm_ext = $urandom; pc_plus4 = $urandom;
            alu_op = 3'($urandom_range(0, 7)); alu_src = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            compare_outputs($sformatf("stall%0d", i), last_exp);
            $display("vec stall%0d   res=%08h z=%0b bt=%08h", i, result, zero, branch_target);
        end

        // Reset mid-stream, then a stalled cycle after release must leave outputs at zero.
        rst_n = 1'b0; en = 1'b1;
        @(posedge clk);
        #1;
        compare_outputs("rst_mid", zero_exp);
        rst_n = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        compare_outputs("rst_hold", zero_exp);
        apply("post_rst", 32'h0000_1000, 32'd100, 32'd58, 32'h0000_0022, 1'b0, 3'b010);

        for (int i = 0; i < 24; i++) begin
            f = functs[$urandom_range(0, 9)];
            apply($sformatf("rnd%0d", i), $urandom, $urandom, $urandom,
                  {$urandom_range(0, 65535) << 16} | {21'd0, 5'($urandom_range(0, 31)), f},
                  1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
